// File: rtl/tree_drainer.sv
// tree_drainer: packs the sorted record stream into 2^P_LOG-record lines and writes
// them to line memory at sequential addresses, with flush, back-pressure and order check.
module tree_drainer #(
    parameter int P_LOG = 3,
    parameter int DATW  = 64,
    parameter int KEYW  = 32,
    parameter int M_LOG = 10
) (
    input  logic                     CLK,
    input  logic                     RST_X,
    input  logic [DATW-1:0]          DIN,
    input  logic                     DINEN,
    output logic                     DIN_RDY,
    input  logic                     FLUSH,
    output logic                     WE,
    output logic [M_LOG-1:0]         WADDR,
    output logic [(DATW<<P_LOG)-1:0] WDOT,
    input  logic                     WRDY,
    output logic [M_LOG:0]           LINE_CNT,
    output logic                     DONE,
    output logic                     ERR_ORDER
);
    localparam int LANES = 1 << P_LOG;
    localparam int LW    = DATW << P_LOG;

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

    state_t           r_state;
    logic [LW-1:0]    r_pack, r_wdot, w_line, w_pad;
    logic [P_LOG-1:0] r_cnt;
    logic             r_full, r_out_v, r_live, r_done, r_err, r_have;
    logic [KEYW-1:0]  r_prev;
    logic [M_LOG-1:0] r_waddr;
    logic [M_LOG:0]   r_line_cnt;
    logic             w_acc, w_wacc, w_free, w_last, w_idle;

    // r_live keeps DIN_RDY low until the first edge after reset release
    assign DIN_RDY   = r_live && r_state == S_RUN && !(r_full && r_out_v);
    assign w_acc     = DINEN && DIN_RDY;
    assign w_wacc    = r_out_v && WRDY;
    assign w_free    = !r_out_v || w_wacc;
    assign w_last    = r_cnt == P_LOG'(LANES - 1);
    assign w_idle    = r_cnt == '0 && !r_full && w_free;
    assign WE        = r_out_v;
    assign WADDR     = r_waddr;
    assign WDOT      = r_wdot;
    assign LINE_CNT  = r_line_cnt;
    assign DONE      = r_done;
    assign ERR_ORDER = r_err;

    always_comb begin
        w_line = r_pack;
        w_line[r_cnt*DATW +: DATW] = DIN;
        w_pad = r_pack;
        for (int i = 0; i < LANES; i++)
            if (i >= int'(r_cnt)) w_pad[i*DATW +: DATW] = '1;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state    <= S_RUN;
            r_pack     <= '0;
            r_wdot     <= '0;
            r_cnt      <= '0;
            r_full     <= 1'b0;
            r_out_v    <= 1'b0;
            r_live     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_have     <= 1'b0;
            r_prev     <= '0;
            r_waddr    <= '0;
            r_line_cnt <= '0;
        end else begin
            r_live <= 1'b1;
            r_done <= 1'b0;
            if (w_wacc) begin
                r_out_v <= 1'b0;
                r_waddr <= r_waddr + 1'b1;
                if (!r_line_cnt[M_LOG]) r_line_cnt <= r_line_cnt + 1'b1;
            end
            // a full line parked in the pack register follows the accepted one immediately
            if (r_full && w_wacc) begin
                r_wdot  <= r_pack;
                r_out_v <= 1'b1;
                r_full  <= 1'b0;
            end
            if (w_acc) begin
                r_cnt  <= r_cnt + 1'b1;
                r_prev <= DIN[KEYW-1:0];
                r_have <= 1'b1;
                if (r_have && DIN[KEYW-1:0] < r_prev) r_err <= 1'b1;
                if (w_last && w_free) begin
                    r_wdot  <= w_line;
                    r_out_v <= 1'b1;
                end else begin
                    r_pack <= w_line;
                    r_full <= w_last;
                end
            end
            if (r_state == S_RUN && FLUSH) begin
                r_state <= (!w_acc && w_idle) ? S_DONE : S_FLUSH;
                r_done  <= !w_acc && w_idle;
            end else if (r_state == S_FLUSH) begin
                if (r_cnt != '0 && !r_full && w_free) begin
                    r_wdot  <= w_pad;
                    r_out_v <= 1'b1;
                    r_cnt   <= '0;
                end else if (w_idle) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
            end else if (r_state == S_DONE) begin
                r_state <= S_RUN;
                r_have  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tree_drainer.sv
// tb_tree_drainer: directed stimulus with a line scoreboard checked by a separate monitor.
module tb_tree_drainer;
    localparam int LW = 512;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [63:0]    din = '0;
    logic           dinen = 1'b0, flush = 1'b0, wrdy = 1'b1;
    logic           din_rdy, we, done, err;
    logic [9:0]     waddr;
    logic [LW-1:0]  wdot;
    logic [10:0]    line_cnt;
    logic           s_rdy, s_we, s_done, s_err;
    logic [1:0]     s_waddr;
    logic [LW-1:0]  s_wdot;
    logic [2:0]     s_line_cnt;

    int             n_cmp = 0, n_err = 0, stalls = 0;
    int             exp_a[$];
    logic [LW-1:0]  exp_d[$];
    int             s_addrs[$];
    logic           cap = 1'b0;

    always #5 clk = ~clk;

    tree_drainer dut (
        .CLK(clk), .RST_X(rst_n), .DIN(din), .DINEN(dinen), .DIN_RDY(din_rdy),
        .FLUSH(flush), .WE(we), .WADDR(waddr), .WDOT(wdot), .WRDY(wrdy),
        .LINE_CNT(line_cnt), .DONE(done), .ERR_ORDER(err)
    );

    tree_drainer #(.M_LOG(2)) dut_s (
        .CLK(clk), .RST_X(rst_n), .DIN(din), .DINEN(dinen), .DIN_RDY(s_rdy),
        .FLUSH(flush), .WE(s_we), .WADDR(s_waddr), .WDOT(s_wdot), .WRDY(wrdy),
        .LINE_CNT(s_line_cnt), .DONE(s_done), .ERR_ORDER(s_err)
    );

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rec(input int k);
        return {32'hC0DE0000 + 32'(k), 32'(k)};
    endfunction

    function automatic logic [LW-1:0] mk(input int k0, input int n);
        logic [LW-1:0] l = '1;
        for (int i = 0; i < n; i++) l[i*64 +: 64] = rec(k0 + i);
        return l;
    endfunction

    task automatic push(input int a, input logic [LW-1:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    // called at a falling edge; returns at the falling edge after acceptance
    task automatic put(input int k);
        int t = 0;
        din = rec(k);
        dinen = 1'b1;
        while (!din_rdy && t < 100) begin @(negedge clk); t++; end
        stalls += t;
        if (t >= 100) chk("put_timeout", 1'b0, 1'b1);
        @(negedge clk);
        dinen = 1'b0;
    endtask

    task automatic flush_wait(input string name);
        int t = 0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        while (!done && t < 50) begin @(negedge clk); t++; end
        chk(name, done, 1'b1);
        @(negedge clk);
    endtask

    // handshake values are stable between the falling edge and the next rising edge
    always begin
        @(negedge clk);
        #1;
        if (rst_n && we && wrdy) begin
            if (exp_a.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
            else begin
                chk("line_addr", LW'(waddr), LW'(exp_a.pop_front()));
                chk("line_data", wdot, exp_d.pop_front());
            end
        end
        if (cap && rst_n && s_we && wrdy) s_addrs.push_back(int'(s_waddr));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [LW-1:0] l;
        #2;
        chk("rst_we", we, 1'b0);
        chk("rst_waddr", LW'(waddr), '0);
        chk("rst_wdot", wdot, '0);
        chk("rst_line_cnt", LW'(line_cnt), '0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rdy", din_rdy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_release", din_rdy, 1'b1);

        // one full line, back to back
        push(0, mk(1, 8));
        stalls = 0;
        for (int k = 1; k <= 8; k++) put(k);
        chk("t1_we_next_cycle", we, 1'b1);
        chk("t1_waddr", LW'(waddr), '0);
        chk("t1_no_stall", LW'(stalls), '0);
        @(negedge clk);
        chk("t1_line_cnt", LW'(line_cnt), LW'(1));

        // empty flush: no write, DONE on next cycle
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t4_done", done, 1'b1);
        chk("t4_no_we", we, 1'b0);
        @(negedge clk);
        chk("t4_done_single", done, 1'b0);
        chk("t4_line_cnt", LW'(line_cnt), LW'(1));

        // back-pressure
        wrdy = 1'b0;
        push(1, mk(1, 8));
        push(2, mk(9, 8));
        push(3, mk(17, 8));
        for (int k = 1; k <= 16; k++) put(k);
        chk("t2_rdy_drop", din_rdy, 1'b0);
        chk("t2_we_held", we, 1'b1);
        chk("t2_waddr_held", LW'(waddr), LW'(1));
        din = rec(17);
        dinen = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_rdy_still_low", din_rdy, 1'b0);
        chk("t2_wdot_held", wdot, mk(1, 8));
        wrdy = 1'b1;
        for (int k = 17; k <= 24; k++) put(k);
        flush_wait("t2_done");
        chk("t2_line_cnt", LW'(line_cnt), LW'(4));

        // partial line flush with padding
        push(4, mk(5, 3));
        for (int k = 5; k <= 7; k++) put(k);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("t3_we", we, 1'b1);
        chk("t3_waddr", LW'(waddr), LW'(4));
        @(negedge clk);
        chk("t3_done", done, 1'b1);
        @(negedge clk);
        chk("t3_line_cnt", LW'(line_cnt), LW'(5));
        chk("t3_no_err", err, 1'b0);

        // order checker
        l = '1;
        l[63:0] = rec(3);
        l[127:64] = rec(4);
        l[191:128] = rec(2);
        push(5, l);
        put(3);
        put(4);
        chk("t6_err_before", err, 1'b0);
        put(2);
        chk("t6_err_set", err, 1'b1);
        flush_wait("t6_done");
        chk("t6_err_sticky", err, 1'b1);
        chk("t6_line_cnt", LW'(line_cnt), LW'(6));

        // reset mid-line
        put(10);
        put(11);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", we, 1'b0);
        chk("mid_rst_waddr", LW'(waddr), '0);
        chk("mid_rst_wdot", wdot, '0);
        chk("mid_rst_line_cnt", LW'(line_cnt), '0);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_rdy", din_rdy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // address wrap and count saturation with M_LOG=2
        cap = 1'b1;
        for (int j = 0; j < 5; j++) push(j, mk(100 + 8*j, 8));
        for (int k = 100; k < 140; k++) put(k);
        repeat (2) @(negedge clk);
        chk("t5_line_cnt", LW'(line_cnt), LW'(5));
        chk("t5_small_line_cnt", LW'(s_line_cnt), LW'(4));
        chk("t5_small_writes", LW'(s_addrs.size()), LW'(5));
        for (int j = 0; j < 5 && j < s_addrs.size(); j++)
            chk($sformatf("t5_small_addr%0d", j), LW'(s_addrs[j]), LW'(j % 4));
        chk("sb_drained", LW'(exp_a.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tree_drainer.md
Name: tree_drainer

Overview:
Write-side counterpart of the tree filler. Consumes the sorted single-record stream leaving the merge sorter tree. Packs 2^P_LOG consecutive records into one wide line and writes the lines to a line-addressed memory (same BRAM format the filler reads) at sequential addresses. Provides back-pressure to the tree, an explicit end-of-stream flush and an in-line sortedness checker for verification.

Parameters:
P_LOG  3   records per line = 2^P_LOG (same packing as the filler's lines)
DATW   64  record width
KEYW   32  key width; key = record[KEYW-1:0]
M_LOG  10  memory address width in lines

Ports:
CLK        in   1               clock, all state on rising edge
RST_X      in   1               reset, asynchronous, active-low
DIN        in   DATW            record from tree output (DOT)
DINEN      in   1               DIN valid (DOTEN)
DIN_RDY    out  1               drainer can accept DIN this cycle
FLUSH      in   1               one-cycle end-of-stream request
WE         out  1               write request; line valid on WDOT/WADDR
WADDR      out  M_LOG           line address
WDOT       out  DATW<<P_LOG     packed line
WRDY       in   1               memory accepts line when WE && WRDY
LINE_CNT   out  M_LOG+1         lines accepted since reset, saturating
DONE       out  1               one-cycle pulse: flush complete
ERR_ORDER  out  1               sticky: key went backwards

Behaviour:
- Reset values, applied immediately while RST_X=0: WE=0, WADDR=0, WDOT=0, LINE_CNT=0, DONE=0, ERR_ORDER=0, DIN_RDY=0, pack count=0, state=RUN. DIN_RDY rises on the first clock edge after release.
- Storage: pack register with lane counter cnt (P_LOG bits) plus one output line register (out_v).
- Packing:
  - Record accepted when DINEN && DIN_RDY; it goes to lane cnt, i.e. bits [DATW*(cnt+1)-1 : DATW*cnt].
  - Lane 0 holds the first record of the line, matching the filler's right-shift read order.
  - DINEN while DIN_RDY=0 is ignored and not counted.
- Line completion: when cnt=2^P_LOG-1 and a record is accepted, the full line (including this record) moves to the output register and cnt wraps to 0.
  - If out_v=0, or the output line is accepted in the same cycle, the move happens at that edge, so WE is high the next cycle.
  - Otherwise the pack register holds full and DIN_RDY=0.
- DIN_RDY = (state==RUN) && !(pack full && out_v). With WRDY permanently high, DIN_RDY stays 1 and sustains one record per cycle.
- Write handshake:
  - WE=out_v. WDOT and WADDR are stable while WE && !WRDY.
  - On WE && WRDY: out_v clears (or reloads from a full pack register the same edge), WADDR increments modulo 2^M_LOG, and LINE_CNT increments, saturating at 2^M_LOG.
- States:
  - RUN → FLUSH on FLUSH=1.
    - A record accepted the same cycle is included in the flushed line.
    - FLUSH in FLUSH or DONE state is ignored.
  - FLUSH: DIN_RDY=0.
    - If cnt>0, lanes cnt..2^P_LOG-1 are padded with all-ones, and the line moves to the output register once out_v=0; cnt becomes 0.
    - If cnt=0, no padding line is written.
    - When cnt=0 and out_v=0 → DONE state.
  - DONE: DONE=1 for exactly one cycle → RUN. WADDR and LINE_CNT are not cleared, so the next stream appends.
- Order check:
  - On each accepted record, if key < key of the previous accepted record since the last reset or DONE, set ERR_ORDER.
  - Equal keys are legal. Padding records are not checked.
  - ERR_ORDER is cleared only by reset.
- Reset mid-line: partial line and pending output are discarded, and no write is issued.

Test Plan:
- WRDY=1; feed keys 1..8 back-to-back → one WE pulse, one cycle after the 8th record; WADDR=0; lane i key=i+1; LINE_CNT=1; DIN_RDY stays 1.
- WRDY=0; stream keys 1..20 continuously → DIN_RDY drops in the cycle after the 16th acceptance; keys 17..20 are held. Raise WRDY → lines written at addresses 0 and 1, then keys 17..20 resume; no record lost or duplicated.
- Feed keys 5,6,7, then FLUSH → one line at the next address: lanes 0-2 = 5,6,7, lanes 3-7 all-ones; DONE pulses one cycle after that write is accepted.
- FLUSH with cnt=0 and out_v=0 → no WE; DONE pulses on the next cycle; LINE_CNT unchanged.
- M_LOG=2: stream 40 records → WADDR sequence 0,1,2,3,0; LINE_CNT saturates at 4.
- Keys 3,4,2 → ERR_ORDER=1 after key 2 and stays 1 across a later FLUSH/DONE. Assert RST_X=0 mid-line → all outputs zero immediately; after release the first write is at WADDR=0.
